// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSB first,
// with a start/busy/done handshake and signed-overflow detection.
module serial_add_sub #(
  parameter int WIDTH = 15,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept, last;
  logic [DIGIT:0]   dfull;
  logic [DIGIT-1:0] dsum;
  logic [WIDTH+DIGIT-1:0] acc_cat;
  logic [WIDTH-1:0] acc_next;
  logic             msb_cin;

  // Operands shift right so the current digit is always the low slice; the
  // result enters at the top of acc and reaches its final alignment after N digits.
  always_comb begin
    dfull    = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    dsum     = dfull[DIGIT-1:0];
    acc_cat  = {dsum, acc};
    acc_next = acc_cat[WIDTH+DIGIT-1:DIGIT];
    msb_cin  = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ dsum[DIGIT-1];
    last     = (cnt == CW'(N - 1));
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN:  if (last) state_next = DONE;
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b ^ {WIDTH{sub}};
      acc   <= '0;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> DIGIT;
      op_b  <= op_b >> DIGIT;
      acc   <= acc_next;
      carry <= dfull[DIGIT];
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum       <= acc_next;
        carry_out <= dfull[DIGIT];
        overflow  <= msb_cin ^ dfull[DIGIT];
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
